// File: rtl/sar_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the SAR scan controller:
//   - sar_state_e : controller state encoding (IDLE, SAMPLE, CONV, DONE)
//   - ch_width()  : channel index width, never narrower than one bit
//   - lowest_set(): index of the lowest set bit of a channel mask (0 if none)
// ---------------------------------------------------------------------------
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      CONV   = 2'd2,
      DONE   = 2'd3
   } sar_state_e;

   // Upper bound on the channel count; masks are widened to this for lookups.
   localparam int MAX_CH = 16;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Scans from the top down so the last hit is the lowest set bit.
   function automatic logic [3:0] lowest_set(input logic [MAX_CH-1:0] m);
      logic [3:0] idx;
      idx = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (m[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sar_scan_controller_if.sv
// ---------------------------------------------------------------------------
// sar_scan_controller_if
// Result channel of the SAR scan controller: a one-entry valid/ready register.
//   res_valid : producer holds a result
//   res_ready : consumer accepts when res_valid & res_ready at a clock edge
//   res_data  : converted code
//   res_ch    : channel the code belongs to
//   res_last  : code is the last channel of its sweep
// master = controller side, slave = consumer side.
// ---------------------------------------------------------------------------
interface sar_scan_controller_if #(
   parameter int WIDTH = 8,
   parameter int CW    = 2
);
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic [CW-1:0]    res_ch;
   logic             res_last;

   modport master (
      output res_valid,
      output res_data,
      output res_ch,
      output res_last,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_data,
      input  res_ch,
      input  res_last,
      output res_ready
   );
endinterface

// File: rtl/sar_ch_picker.sv
// ---------------------------------------------------------------------------
// sar_ch_picker
// Combinational channel walker for the scan controller.
//   mask_i       : channel mask to walk
//   cur_i        : index of the channel just converted
//   next_idx_o   : lowest enabled channel strictly above cur_i
//   has_next_o   : a channel above cur_i is enabled
//   lowest_idx_o : lowest enabled channel of mask_i (0 when mask_i is empty)
// ---------------------------------------------------------------------------
module sar_ch_picker
   import sar_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CW     = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [CW-1:0]     cur_i,
   output logic [CW-1:0]     next_idx_o,
   output logic              has_next_o,
   output logic [CW-1:0]     lowest_idx_o
);

   always_comb begin
      next_idx_o = '0;
      has_next_o = 1'b0;
      // Top-down scan: the last match is the nearest channel above cur_i.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i] && (i > int'(cur_i))) begin
            next_idx_o = CW'(i);
            has_next_o = 1'b1;
         end
      end
   end

   assign lowest_idx_o = CW'(lowest_set(MAX_CH'(mask_i)));

endmodule

// File: rtl/sar_scan_controller.sv
// ---------------------------------------------------------------------------
// sar_scan_controller
// Successive-approximation ADC controller scanning a mask of channels.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request one sweep, honoured only when idle
//   cont_mode  : restart sweeps back-to-back, sampled at end of each sweep
//   abort      : synchronous return to idle, discards the conversion in flight
//   ch_mask    : enabled channels, latched at sweep start
//   cmp        : comparator, 1 = analog input >= dac_value
//   sample     : sample-and-hold enable
//   ch_sel     : analog mux select
//   dac_value  : DAC trial code (result | bit_mask)
//   busy       : controller is not idle
//   res_if     : one-entry valid/ready result register (master side)
// ---------------------------------------------------------------------------
module sar_scan_controller
   import sar_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int NUM_CH        = 4,
   parameter int SAMPLE_CYCLES = 1,
   parameter int CW            = ch_width(NUM_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  cont_mode,
   input  logic                  abort,
   input  logic [NUM_CH-1:0]     ch_mask,
   input  logic                  cmp,
   output logic                  sample,
   output logic [CW-1:0]         ch_sel,
   output logic [WIDTH-1:0]      dac_value,
   output logic                  busy,
   sar_scan_controller_if.master res_if
);

   localparam int SCW = $clog2(SAMPLE_CYCLES + 1);
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   sar_state_e        state_q;
   logic [SCW-1:0]    sample_cnt_q;
   logic [NUM_CH-1:0] mask_q;
   logic [CW-1:0]     ch_sel_q;
   logic [WIDTH-1:0]  result_q;
   logic [WIDTH-1:0]  bit_mask_q;
   logic              res_valid_q;
   logic [WIDTH-1:0]  res_data_q;
   logic [CW-1:0]     res_ch_q;
   logic              res_last_q;

   // While idle the picker looks at the live mask so the first channel is
   // known on the start edge; in DONE it walks the latched mask.
   logic [NUM_CH-1:0] pick_mask;
   logic [CW-1:0]     pick_next;
   logic              pick_has_next;
   logic [CW-1:0]     pick_lowest;
   logic [CW-1:0]     new_lowest;
   logic              out_free;

   assign pick_mask  = (state_q == DONE) ? mask_q : ch_mask;
   assign new_lowest = CW'(lowest_set(MAX_CH'(ch_mask)));
   assign out_free   = !res_valid_q || res_if.res_ready;

   sar_ch_picker #(
      .NUM_CH (NUM_CH),
      .CW     (CW)
   ) u_picker (
      .mask_i       (pick_mask),
      .cur_i        (ch_sel_q),
      .next_idx_o   (pick_next),
      .has_next_o   (pick_has_next),
      .lowest_idx_o (pick_lowest)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sample_cnt_q <= '0;
         mask_q       <= '0;
         ch_sel_q     <= '0;
         result_q     <= '0;
         bit_mask_q   <= '0;
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_ch_q     <= '0;
         res_last_q   <= 1'b0;
      end else begin
         // Consumption first; a load in DONE below overrides it.
         if (res_valid_q && res_if.res_ready) res_valid_q <= 1'b0;

         if (abort) begin
            // Result register is deliberately left alone.
            state_q      <= IDLE;
            sample_cnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start && (ch_mask != '0)) begin
                     mask_q       <= ch_mask;
                     ch_sel_q     <= pick_lowest;
                     sample_cnt_q <= '0;
                     state_q      <= SAMPLE;
                  end
               end

               SAMPLE: begin
                  if (sample_cnt_q == SCW'(SAMPLE_CYCLES - 1)) begin
                     sample_cnt_q <= '0;
                     bit_mask_q   <= MSB_MASK;
                     result_q     <= '0;
                     state_q      <= CONV;
                  end else begin
                     sample_cnt_q <= sample_cnt_q + 1'b1;
                  end
               end

               CONV: begin
                  if (cmp) result_q <= result_q | bit_mask_q;
                  bit_mask_q <= bit_mask_q >> 1;
                  if (bit_mask_q[0]) state_q <= DONE;
               end

               DONE: begin
                  // Stall here until the output register can take the code.
                  if (out_free) begin
                     res_valid_q <= 1'b1;
                     res_data_q  <= result_q;
                     res_ch_q    <= ch_sel_q;
                     res_last_q  <= !pick_has_next;
                     if (pick_has_next) begin
                        ch_sel_q     <= pick_next;
                        sample_cnt_q <= '0;
                        state_q      <= SAMPLE;
                     end else if (cont_mode && (ch_mask != '0)) begin
                        mask_q       <= ch_mask;
                        ch_sel_q     <= new_lowest;
                        sample_cnt_q <= '0;
                        state_q      <= SAMPLE;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
               end

               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Outputs decode straight from registers, so they are glitch-free.
   assign sample    = (state_q == SAMPLE);
   assign busy      = (state_q != IDLE);
   assign ch_sel    = ch_sel_q;
   assign dac_value = result_q | bit_mask_q;

   assign res_if.res_valid = res_valid_q;
   assign res_if.res_data  = res_data_q;
   assign res_if.res_ch    = res_ch_q;
   assign res_if.res_last  = res_last_q;

endmodule

// File: doc/sar_scan_controller.md
Name: sar_scan_controller

Overview:
- Parametrised successive-approximation ADC controller, successor to the single-channel 8-bit SAR sequencer.
- Drives an external sample-and-hold, analog channel mux, DAC and comparator.
- Scans a mask of channels per sweep, in single-shot or continuous mode.
- Delivers results through a one-entry valid/ready output register with backpressure.

Parameters:
- WIDTH, 8: conversion resolution in bits, 2..16.
- NUM_CH, 4: number of analog channels, 1..16.
- SAMPLE_CYCLES, 1: cycles `sample` stays high per conversion, >=1.
- CW, max(1,$clog2(NUM_CH)): channel index width, derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one sweep; honoured only in IDLE.
- cont_mode  in  1  1 = restart sweeps back-to-back; checked at end of each sweep.
- abort  in  1  synchronous abort to IDLE.
- ch_mask  in  NUM_CH  enabled channels; latched at sweep start.
- cmp  in  1  comparator output: 1 = input >= dac_value.
- sample  out  1  sample-and-hold enable.
- ch_sel  out  CW  analog mux select; stable SAMPLE through DONE.
- dac_value  out  WIDTH  DAC trial code, result|bit_mask.
- busy  out  1  state != IDLE.
- res_valid  out  1  output register holds a result.
- res_ready  in  1  consumer accepts when res_valid & res_ready.
- res_data  out  WIDTH  converted code.
- res_ch  out  CW  channel of res_data.
- res_last  out  1  result is the last channel of its sweep.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - sample, busy, res_valid, res_last = 0.
  - ch_sel, res_ch, res_data, dac_value, internal result/bit_mask/counters/latched mask = 0.
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE:
  - start=1 and ch_mask!=0: latch ch_mask, ch_sel = lowest set bit, sample counter=0, go to SAMPLE.
  - start=1 and ch_mask==0: stay in IDLE, no output activity.
- SAMPLE:
  - sample=1 for exactly SAMPLE_CYCLES cycles.
  - On the last cycle: bit_mask=1<<(WIDTH-1), result=0, go to CONV.
- CONV (exactly WIDTH cycles):
  - Each cycle: if cmp, result |= bit_mask; then bit_mask >>= 1.
  - When bit_mask[0]=1, go to DONE.
  - dac_value = result|bit_mask, combinational from registers.
  - Outside CONV/DONE, dac_value holds the result|bit_mask register value.
- DONE:
  - If output register is free (res_valid=0, or res_valid&res_ready this cycle): load res_data=result, res_ch=ch_sel, res_last=(no higher latched channel), res_valid=1.
  - Then: next higher latched channel exists -> SAMPLE with it; else cont_mode=1 -> SAMPLE with lowest latched channel, re-latching ch_mask (if the new mask==0 -> IDLE); else -> IDLE.
  - If output register is not free: stall in DONE. No result is ever dropped.
- Output register:
  - res_valid clears on res_valid&res_ready unless reloaded in the same cycle.
  - Simultaneous consume+load leaves res_valid=1 with the new data.
- Latency: start accepted at edge E0 -> res_valid=1 after edge E0+SAMPLE_CYCLES+WIDTH+1 (no backpressure).
- Sweep-to-sweep: no IDLE cycle in continuous mode.
- abort=1 (highest priority after reset):
  - Next edge -> IDLE; sample=0; in-flight conversion discarded.
  - Output register untouched.
  - start in the same cycle is ignored.
- Ignored or deferred inputs:
  - start while busy: ignored.
  - ch_mask changes mid-sweep: ignored.
  - cont_mode deasserted mid-sweep: current sweep completes, then IDLE.
- Arithmetic:
  - All register widths exactly WIDTH/CW; no overflow is possible.
  - NUM_CH=1: ch_sel, res_ch tie to 0; res_last=1 always.

Decomposition:
- Package sar_pkg: state enum (IDLE, SAMPLE, CONV, DONE) and a clog2-based channel-width function.
- One sub-module, sar_ch_picker: combinational, takes latched mask and current index, returns next-higher enabled index, lowest enabled index, and has_next flag.

Test Plan (WIDTH=8, NUM_CH=4, SAMPLE_CYCLES=2; comparator model cmp=(vin[ch_sel]>=dac_value); res_ready=1 unless stated):
- T1, latency and code: ch_mask=0010, vin[1]=0xA5, start pulse -> one result 0xA5, res_ch=1, res_last=1, res_valid 11 edges after start; busy drops next cycle; dac_value sequence 80,C0,A0,B0,A8,A4,A6,A5.
- T2, sweep order and extremes: ch_mask=1011, vin=0x00/0xFF/-/0x7F -> results (0,0x00),(1,0xFF),(3,0x7F); res_last only on ch3.
- T3, continuous restart: cont_mode=1, ch_mask=0101 -> ch0,ch2,ch0,ch2... with no IDLE cycle between sweeps; drop cont_mode mid-ch0 -> ch2 completes, then IDLE.
- T4, backpressure: res_ready=0 for 30 cycles during a 2-channel sweep -> FSM stalls in DONE after the 2nd conversion; both results delivered in order once res_ready=1; none lost.
- T5, abort: assert abort on the 3rd CONV cycle -> IDLE next edge, sample=0, no new res_valid; earlier pending result remains valid.
- T6, reset and null mask: rst_n low mid-CONV -> all outputs 0 immediately (asynchronous); start with ch_mask=0 -> busy stays 0.
